// File: rtl/pwm_pkg.sv
// Shared widths and the per-channel configuration record for the PWM generator.
package pwm_pkg;

  localparam int PWM_NUM_CH = 4;
  localparam int PWM_CNT_W  = 16;
  localparam int PWM_PRE_W  = 8;

  // One channel's settings; used for both the active and the shadow copy.
  typedef struct packed {
    logic                 en;
    logic [PWM_CNT_W-1:0] period;
    logic [PWM_CNT_W-1:0] high;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active/shadow settings, pending flag, period counter and
// registered output/wrap. Shadow settings are promoted only at a period end
// so a reconfiguration never produces a runt pulse.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick_i,
  input  logic     wr_i,
  input  pwm_cfg_t wr_cfg_i,
  output logic     pend_o,
  output logic     clk_out_o,
  output logic     wrap_o
);

  pwm_cfg_t             act_q, act_d;
  pwm_cfg_t             shd_q, shd_d;
  logic                 pend_q, pend_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 wrap_p_q;
  logic                 wrap_q;
  logic                 running;
  logic                 at_end;

  // A channel only counts when enabled with a nonzero period.
  assign running = act_q.en && (act_q.period != '0);
  assign at_end  = running && tick_i && (cnt_q == act_q.period - PWM_CNT_W'(1));

  // Next-state: counter advance, shadow promotion at wrap, then write handling.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (at_end) begin
      cnt_d = '0;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (running && tick_i) begin
      cnt_d = cnt_q + PWM_CNT_W'(1);
    end
    if (wr_i) begin
      if (!wr_cfg_i.en) begin
        // Disable is immediate and drops any queued update.
        act_d  = wr_cfg_i;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (running) begin
        shd_d  = wr_cfg_i;
        pend_d = 1'b1;
      end else begin
        // Idle channel: nothing to protect, start the new waveform now.
        act_d = wr_cfg_i;
        cnt_d = '0;
      end
    end
    out_d = running && (cnt_q < act_q.high);
  end

  // State registers. Wrap is delayed twice so it lines up with the first
  // output cycle of the new period (the output itself lags cnt by one).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q    <= '0;
      shd_q    <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      wrap_p_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      act_q    <= act_d;
      shd_q    <= shd_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      wrap_p_q <= at_end;
      wrap_q   <= wrap_p_q;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = out_q;
  assign wrap_o    = wrap_q;

endmodule

// File: rtl/pwm_clock_gen.sv
// Multi-channel programmable clock/PWM generator: shared prescaler, config
// write decode with valid/ready backpressure, and NUM_CH channel instances.
// The config record width is fixed by pwm_pkg::PWM_CNT_W; CNT_W sizes the
// ports and is expected to match it.
module pwm_clock_gen
  import pwm_pkg::*;
#(
  parameter  int NUM_CH = PWM_NUM_CH,
  parameter  int CNT_W  = PWM_CNT_W,
  parameter  int PRE_W  = PWM_PRE_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] wrap
);

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick;
  logic              accept;
  logic [NUM_CH-1:0] pend;
  pwm_cfg_t          wr_cfg;

  // ">=" rather than "==" so lowering prescale below pre_cnt ticks at once.
  assign tick      = (pre_cnt_q >= prescale);
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);

  // Shared prescaler counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // Ready follows the addressed channel's pending flag; unknown channels
  // always accept so the writer never deadlocks on a bad address.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

  assign accept = cfg_valid && cfg_ready;
  assign wr_cfg = '{en: cfg_en, period: cfg_period, high: cfg_high};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .wr_i      (accept && (cfg_ch == CH_W'(g))),
      .wr_cfg_i  (wr_cfg),
      .pend_o    (pend[g]),
      .clk_out_o (clk_out[g]),
      .wrap_o    (wrap[g])
    );
  end

endmodule

// File: tb/tb_pwm_clock_gen.sv
// Directed bench for pwm_clock_gen. Three channels are instantiated so that
// cfg_ch = 3 is a genuinely out-of-range address.
module tb_pwm_clock_gen;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int PW  = 8;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PW-1:0]  prescale;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic           cfg_en;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_high;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] wrap;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_clock_gen #(.NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prescale   (prescale),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .clk_out    (clk_out),
    .wrap       (wrap)
  );

  // Called at a falling edge; returns at the falling edge after the accepting
  // rising edge. st = number of cycles the write was held off.
  task automatic cfg_write(input int ch, input logic en, input int p, input int h,
                           output int st);
    cfg_ch     = CHW'(ch);
    cfg_en     = en;
    cfg_period = CW'(p);
    cfg_high   = CW'(h);
    cfg_valid  = 1'b1;
    st = 0;
    #1;
    while (!cfg_ready && st < 100) begin
      @(negedge clk); #1;
      st++;
    end
    n_cmp++;
    if (st >= 100) begin
      n_bad++;
      $display("FAIL cfg_write_timeout ch=%0d ready stuck at %b, want 1", ch, cfg_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (clk_out !== '0) begin n_bad++; $display("FAIL reset_clk_out got %b want 000", clk_out); end
    n_cmp++;
    if (wrap !== '0) begin n_bad++; $display("FAIL reset_wrap got %b want 000", wrap); end
    for (int c = 0; c < 4; c++) begin
      cfg_ch = CHW'(c);
      #1;
      n_cmp++;
      if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready ch=%0d got %b want 1", c, cfg_ready); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (clk_out !== '0) begin n_bad++; $display("FAIL reset_idle got %b want 000", clk_out); end
  endtask

  task automatic test_basic;
    int  st;
    logic eo, ew;
    do_reset;
    prescale = '0;
    cfg_write(0, 1'b1, 4, 1, st);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      eo = (k % 4 == 1);
      ew = eo && (k > 1);
      n_cmp++;
      if (clk_out[0] !== eo) begin n_bad++; $display("FAIL basic_out k=%0d got %b want %b", k, clk_out[0], eo); end
      n_cmp++;
      if (wrap[0] !== ew) begin n_bad++; $display("FAIL basic_wrap k=%0d got %b want %b", k, wrap[0], ew); end
    end
  endtask

  task automatic test_prescale;
    int st, guard, hi, lo;
    logic others;
    do_reset;
    prescale = 8'd2;
    cfg_write(1, 1'b1, 5, 2, st);
    guard = 0;
    while (clk_out[1] !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    while (clk_out[1] !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
    while (clk_out[1] !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 100) begin n_bad++; $display("FAIL pre_sync_timeout waited %0d cycles, want < 100", guard); end
    n_cmp++;
    if (wrap[1] !== 1'b1) begin n_bad++; $display("FAIL pre_wrap_at_rise got %b want 1", wrap[1]); end
    others = 1'b0;
    for (int r = 0; r < 2; r++) begin
      hi = 0;
      while (clk_out[1] === 1'b1 && hi < 50) begin
        others |= clk_out[0] | clk_out[2];
        hi++; @(negedge clk);
      end
      lo = 0;
      while (clk_out[1] === 1'b0 && lo < 50) begin
        others |= clk_out[0] | clk_out[2];
        lo++; @(negedge clk);
      end
      n_cmp++;
      if (hi != 6) begin n_bad++; $display("FAIL pre_high r=%0d got %0d cycles want 6", r, hi); end
      n_cmp++;
      if (lo != 9) begin n_bad++; $display("FAIL pre_low r=%0d got %0d cycles want 9", r, lo); end
    end
    n_cmp++;
    if (others !== 1'b0) begin n_bad++; $display("FAIL pre_others got %b want 0", others); end
  endtask

  task automatic test_double_buffer;
    int  st;
    logic eo, ew;
    do_reset;
    prescale = '0;
    cfg_write(0, 1'b1, 4, 1, st);
    @(negedge clk);
    n_cmp++;
    if (clk_out[0] !== 1'b1) begin n_bad++; $display("FAIL db_k1 got %b want 1", clk_out[0]); end
    @(negedge clk);
    cfg_write(0, 1'b1, 8, 4, st);
    n_cmp++;
    if (st != 0) begin n_bad++; $display("FAIL db_first_stall got %0d want 0", st); end
    // k=3: second write offered while the first is pending
    cfg_ch = '0; cfg_en = 1'b1; cfg_period = CW'(2); cfg_high = CW'(1);
    cfg_valid = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL db_ready_k3 got %b want 0", cfg_ready); end
    n_cmp++;
    if (clk_out[0] !== 1'b0) begin n_bad++; $display("FAIL db_out_k3 got %b want 0", clk_out[0]); end
    @(negedge clk); #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL db_ready_k4 got %b want 1", cfg_ready); end
    n_cmp++;
    if (clk_out[0] !== 1'b0) begin n_bad++; $display("FAIL db_out_k4 got %b want 0", clk_out[0]); end
    @(negedge clk);
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL db_ready_k5 got %b want 0", cfg_ready); end
    for (int k = 5; k <= 16; k++) begin
      if (k > 5) @(negedge clk);
      eo = (k >= 5 && k <= 8) || k == 13 || k == 15;
      ew = (k == 5) || (k == 13) || (k == 15);
      n_cmp++;
      if (clk_out[0] !== eo) begin n_bad++; $display("FAIL db_out k=%0d got %b want %b", k, clk_out[0], eo); end
      n_cmp++;
      if (wrap[0] !== ew) begin n_bad++; $display("FAIL db_wrap k=%0d got %b want %b", k, wrap[0], ew); end
    end
  endtask

  task automatic test_edges;
    int st, w0, w2;
    do_reset;
    prescale = '0;
    cfg_write(0, 1'b1, 0, 3, st);
    cfg_write(1, 1'b1, 4, 0, st);
    cfg_write(2, 1'b1, 4, 7, st);
    repeat (2) @(negedge clk);
    w0 = 0; w2 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (clk_out !== 3'b100) begin n_bad++; $display("FAIL edge_out k=%0d got %b want 100", k, clk_out); end
      if (wrap[0] === 1'b1) w0++;
      if (wrap[2] === 1'b1) w2++;
    end
    n_cmp++;
    if (w0 != 0) begin n_bad++; $display("FAIL edge_wrap_p0 got %0d want 0", w0); end
    n_cmp++;
    if (w2 != 3) begin n_bad++; $display("FAIL edge_wrap_full got %0d want 3", w2); end
  endtask

  task automatic test_disable;
    int st;
    do_reset;
    prescale = '0;
    cfg_write(2, 1'b1, 8, 4, st);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (clk_out[2] !== 1'b1) begin n_bad++; $display("FAIL dis_pre got %b want 1", clk_out[2]); end
    cfg_write(2, 1'b0, 8, 4, st);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (clk_out[2] !== 1'b0 || wrap[2] !== 1'b0) begin
        n_bad++; $display("FAIL dis_off k=%0d got out=%b wrap=%b want 0/0", k, clk_out[2], wrap[2]);
      end
    end
    cfg_ch = CHW'(2); #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL dis_ready got %b want 1", cfg_ready); end
    cfg_ch = CHW'(3); #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL oor_ready got %b want 1", cfg_ready); end
    @(negedge clk);
    cfg_write(3, 1'b1, 4, 1, st);
    n_cmp++;
    if (st != 0) begin n_bad++; $display("FAIL oor_stall got %0d want 0", st); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (clk_out !== '0 || wrap !== '0) begin
        n_bad++; $display("FAIL oor_quiet k=%0d got out=%b wrap=%b want 000/000", k, clk_out, wrap);
      end
    end
  endtask

  task automatic test_async_reset;
    int st;
    do_reset;
    prescale = '0;
    cfg_write(0, 1'b1, 4, 2, st);
    cfg_write(1, 1'b1, 6, 6, st);
    cfg_write(2, 1'b1, 3, 7, st);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (clk_out[2:1] !== 2'b11) begin n_bad++; $display("FAIL ar_running got %b want 11", clk_out[2:1]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (clk_out !== '0) begin n_bad++; $display("FAIL ar_out got %b want 000", clk_out); end
    n_cmp++;
    if (wrap !== '0) begin n_bad++; $display("FAIL ar_wrap got %b want 000", wrap); end
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = CHW'(c); #1;
      n_cmp++;
      if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ar_ready ch=%0d got %b want 1", c, cfg_ready); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (clk_out !== '0 || wrap !== '0) begin
        n_bad++; $display("FAIL ar_idle k=%0d got out=%b wrap=%b want 000/000", k, clk_out, wrap);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    prescale   = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_en     = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    test_reset;
    test_basic;
    test_prescale;
    test_double_buffer;
    test_edges;
    test_disable;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
